// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-line instruction cache.
//
// Sits between the instruction fetcher (IF_* side) and the memory controller
// (IC_* side). One fetch is handled at a time. Hits are answered from local
// storage one cycle after the request is sampled. A miss issues a single
// 4-byte read to the memory controller, fills the line and returns the word.
//
// Ports
//   clk         system clock, all state changes on posedge
//   rst         synchronous active-high reset (clears all valid bits)
//   rdy         global ready; 0 freezes the block, except that a MISS still
//               accepts IC_success
//   clr         pipeline flush; aborts any in-flight fetch, keeps array contents
//   IF_S        fetch request (level), IF_pos held stable until IF_success
//   IF_pos      byte address of the instruction, bits [1:0] ignored
//   IF_success  registered: IF_inst is valid
//   IF_inst     registered instruction word
//   IC_S        registered read request to the memory controller (level)
//   IC_pos      registered word-aligned read address
//   IC_success  one-cycle pulse from the memory controller: IC_value valid
//   IC_value    word read from memory
// -----------------------------------------------------------------------------
module icache #(
  parameter int LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        IF_S,
  input  logic [31:0] IF_pos,
  output logic        IF_success,
  output logic [31:0] IF_inst,
  output logic        IC_S,
  output logic [31:0] IC_pos,
  input  logic        IC_success,
  input  logic [31:0] IC_value
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - IDX - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        if_success_q, if_success_d;
  logic [31:0] if_inst_q,    if_inst_d;
  logic        ic_s_q,       ic_s_d;
  logic [31:0] ic_pos_q,     ic_pos_d;

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic            hit;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            fill_we;

  // Address decode and hit detection for the current fetch request.
  always_comb begin
    req_idx  = IF_pos[IDX+1:2];
    req_tag  = IF_pos[31:IDX+2];
    hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    fill_idx = ic_pos_q[IDX+1:2];
    fill_tag = ic_pos_q[31:IDX+2];
    // The returned word is correct for IC_pos, so it is written even when a
    // flush coincides or rdy is low; otherwise the read would be wasted.
    fill_we  = (state_q == ST_MISS) && IC_success;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy && IF_S) begin
            state_d = hit ? ST_WAIT : ST_MISS;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MISS: begin
          // Accepted regardless of rdy: the controller never repeats the pulse.
          if (IC_success) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_MISS;
          end
        end
        ST_WAIT: begin
          if (rdy) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    if_success_d = if_success_q;
    if_inst_d    = if_inst_q;
    ic_s_d       = ic_s_q;
    ic_pos_d     = ic_pos_q;
    if (clr) begin
      if_success_d = 1'b0;
      ic_s_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy && IF_S) begin
            if (hit) begin
              if_success_d = 1'b1;
              if_inst_d    = data_q[req_idx];
            end else begin
              ic_s_d   = 1'b1;
              ic_pos_d = {IF_pos[31:2], 2'b00};
            end
          end else begin
            if_success_d = if_success_q;
          end
        end
        ST_MISS: begin
          if (IC_success) begin
            if_success_d = 1'b1;
            if_inst_d    = IC_value;
            ic_s_d       = 1'b0;
          end else begin
            ic_s_d = 1'b1;
          end
        end
        ST_WAIT: begin
          // With rdy low the pulse is held so the frozen fetcher still sees it.
          if (rdy) begin
            if_success_d = 1'b0;
          end else begin
            if_success_d = if_success_q;
          end
        end
        default: begin
          if_success_d = 1'b0;
          ic_s_d       = 1'b0;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_success_q <= 1'b0;
      if_inst_q    <= 32'h0000_0000;
      ic_s_q       <= 1'b0;
      ic_pos_q     <= 32'h0000_0000;
    end else begin
      if_success_q <= if_success_d;
      if_inst_q    <= if_inst_d;
      ic_s_q       <= ic_s_d;
      ic_pos_q     <= ic_pos_d;
    end
  end

  // Valid bits: cleared on reset, set on fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and data storage; no reset needed since valid guards them.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= IC_value;
    end
  end

  assign IF_success = if_success_q;
  assign IF_inst    = if_inst_q;
  assign IC_S       = ic_s_q;
  assign IC_pos     = ic_pos_q;

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic        IF_S = 1'b0;
  logic [31:0] IF_pos = 32'h0;
  logic        IF_success;
  logic [31:0] IF_inst;
  logic        IC_S;
  logic [31:0] IC_pos;
  logic        IC_success = 1'b0;
  logic [31:0] IC_value = 32'h0;

  int errors = 0;
  int checks = 0;

  // rising-edge counters sampled on negedge
  int ic_req_cnt = 0;
  int if_succ_cnt = 0;
  logic ic_s_prev = 1'b0;
  logic if_succ_prev = 1'b0;

  icache #(.LINES(256)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .IF_S(IF_S), .IF_pos(IF_pos), .IF_success(IF_success), .IF_inst(IF_inst),
    .IC_S(IC_S), .IC_pos(IC_pos), .IC_success(IC_success), .IC_value(IC_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (IC_S && !ic_s_prev) ic_req_cnt <= ic_req_cnt + 1;
    if (IF_success && !if_succ_prev) if_succ_cnt <= if_succ_cnt + 1;
    ic_s_prev    <= IC_S;
    if_succ_prev <= IF_success;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (IF_success !== 1'b0) begin errors++; $display("FAIL reset_if_success got=%b exp=0", IF_success); end
    checks++;
    if (IF_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst got=%h exp=0", IF_inst); end
    checks++;
    if (IC_S !== 1'b0) begin errors++; $display("FAIL reset_ic_s got=%b exp=0", IC_S); end
    checks++;
    if (IC_pos !== 32'h0) begin errors++; $display("FAIL reset_ic_pos got=%h exp=0", IC_pos); end
  endtask

  // Full miss transaction; memory answers after 'delay' extra cycles.
  task automatic do_miss(input string nm, input logic [31:0] addr, input logic [31:0] val, input int delay);
    int req0;
    req0 = ic_req_cnt;
    IF_S = 1'b1;
    IF_pos = addr;
    step();
    checks++;
    if (IC_S !== 1'b1 || IC_pos !== {addr[31:2], 2'b00} || IF_success !== 1'b0) begin
      errors++; $display("FAIL %s_req ic_s=%b ic_pos=%h if_success=%b exp ic_s=1 ic_pos=%h if_success=0", nm, IC_S, IC_pos, IF_success, {addr[31:2], 2'b00});
    end
    for (int i = 0; i < delay; i++) step();
    checks++;
    if (IC_S !== 1'b1) begin errors++; $display("FAIL %s_hold ic_s=%b exp=1", nm, IC_S); end
    IC_success = 1'b1;
    IC_value = val;
    step();
    IC_success = 1'b0;
    IF_S = 1'b0;
    checks++;
    if (IF_success !== 1'b1 || IF_inst !== val || IC_S !== 1'b0) begin
      errors++; $display("FAIL %s_resp if_success=%b if_inst=%h ic_s=%b exp 1 %h 0", nm, IF_success, IF_inst, IC_S, val);
    end
    step();
    checks++;
    if (IF_success !== 1'b0 || IC_S !== 1'b0) begin
      errors++; $display("FAIL %s_bubble if_success=%b ic_s=%b exp 0 0", nm, IF_success, IC_S);
    end
    checks++;
    if (ic_req_cnt - req0 !== 1) begin errors++; $display("FAIL %s_reqcnt got=%0d exp=1", nm, ic_req_cnt - req0); end
  endtask

  task automatic do_hit(input string nm, input logic [31:0] addr, input logic [31:0] val);
    int req0;
    req0 = ic_req_cnt;
    IF_S = 1'b1;
    IF_pos = addr;
    step();
    IF_S = 1'b0;
    checks++;
    if (IF_success !== 1'b1 || IF_inst !== val || IC_S !== 1'b0) begin
      errors++; $display("FAIL %s_hit if_success=%b if_inst=%h ic_s=%b exp 1 %h 0", nm, IF_success, IF_inst, IC_S, val);
    end
    step();
    checks++;
    if (IF_success !== 1'b0 || ic_req_cnt !== req0) begin
      errors++; $display("FAIL %s_hit_after if_success=%b reqs=%0d exp 0 0", nm, IF_success, ic_req_cnt - req0);
    end
  endtask

  task automatic test_cold_miss();
    do_miss("cold", 32'h0000_0004, 32'h0010_0093, 2);
  endtask

  task automatic test_hit_after_fill();
    do_hit("hit4", 32'h0000_0004, 32'h0010_0093);
  endtask

  task automatic test_conflict();
    do_miss("evict404", 32'h0000_0404, 32'hDEAD_BEEF, 1);
    do_hit("hit404", 32'h0000_0404, 32'hDEAD_BEEF);
    do_miss("refetch4", 32'h0000_0004, 32'h0010_0093, 0);
    do_hit("rehit4", 32'h0000_0004, 32'h0010_0093);
  endtask

  task automatic test_flush_mid_miss();
    int s0;
    s0 = if_succ_cnt;
    IF_S = 1'b1;
    IF_pos = 32'h0000_000C;
    step();
    step();
    clr = 1'b1;
    IF_S = 1'b0;
    step();
    clr = 1'b0;
    checks++;
    if (IC_S !== 1'b0 || IF_success !== 1'b0) begin
      errors++; $display("FAIL flush_mid ic_s=%b if_success=%b exp 0 0", IC_S, IF_success);
    end
    step();
    step();
    checks++;
    if (if_succ_cnt !== s0 || IC_S !== 1'b0) begin
      errors++; $display("FAIL flush_mid_quiet succ=%0d ic_s=%b exp 0 0", if_succ_cnt - s0, IC_S);
    end
    do_miss("after_flush", 32'h0000_000C, 32'h0000_0013, 1);
  endtask

  task automatic test_flush_with_success();
    int s0;
    s0 = if_succ_cnt;
    IF_S = 1'b1;
    IF_pos = 32'h0000_0008;
    step();
    step();
    IC_success = 1'b1;
    IC_value = 32'h1234_5678;
    clr = 1'b1;
    IF_S = 1'b0;
    step();
    IC_success = 1'b0;
    clr = 1'b0;
    step();
    checks++;
    if (if_succ_cnt !== s0 || IF_success !== 1'b0 || IC_S !== 1'b0) begin
      errors++; $display("FAIL flush_succ succ=%0d if_success=%b ic_s=%b exp 0 0 0", if_succ_cnt - s0, IF_success, IC_S);
    end
    do_hit("flush_fill8", 32'h0000_0008, 32'h1234_5678);
  endtask

  task automatic test_clr_hit();
    IF_S = 1'b1;
    IF_pos = 32'h0000_0008;
    clr = 1'b1;
    step();
    clr = 1'b0;
    IF_S = 1'b0;
    checks++;
    if (IF_success !== 1'b0) begin errors++; $display("FAIL clr_hit if_success=%b exp=0", IF_success); end
    step();
  endtask

  task automatic test_rdy_gap();
    int req0, s0;
    logic seen;
    logic [31:0] got;
    req0 = ic_req_cnt;
    s0 = if_succ_cnt;
    seen = 1'b0;
    got = 32'h0;
    IF_S = 1'b1;
    IF_pos = 32'h0000_0010;
    step();
    rdy = 1'b0;
    step();
    IC_success = 1'b1;
    IC_value = 32'hCAFE_F00D;
    step();
    IC_success = 1'b0;
    IF_S = 1'b0;
    step();
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (IF_success === 1'b1 && !seen) begin seen = 1'b1; got = IF_inst; end
      step();
    end
    checks++;
    if (!seen || got !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rdy_gap_resp seen=%b inst=%h exp 1 cafef00d", seen, got);
    end
    checks++;
    if (if_succ_cnt - s0 !== 1) begin errors++; $display("FAIL rdy_gap_pulses got=%0d exp=1", if_succ_cnt - s0); end
    checks++;
    if (ic_req_cnt - req0 !== 1 || IC_S !== 1'b0) begin
      errors++; $display("FAIL rdy_gap_reqs got=%0d ic_s=%b exp 1 0", ic_req_cnt - req0, IC_S);
    end
    do_hit("rdy_gap_fill", 32'h0000_0010, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_clears();
    test_reset();
    do_miss("post_reset4", 32'h0000_0004, 32'h0000_0001, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict();
    test_flush_mid_miss();
    test_flush_with_success();
    test_clr_hit();
    test_rdy_gap();
    test_reset_clears();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
